// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Purpose  : Shared types and constants for the two-master bus arbiter.
//            - bus_req_t   : one master's request bundle (address, data,
//                            byte mask and the level-held read/write strobes)
//            - arb_state_t : arbiter FSM state (IDLE / BUSY)
//            - BUS_ERR_RDATA : read data returned on a watchdog timeout
//            - wdog_width()  : watchdog counter width for a timeout limit
// Revision : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        wen;
        logic        ren;
    } bus_req_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;

    // Master identifiers as used for owner / rr_last bookkeeping.
    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    // Watchdog counter must hold the value TIMEOUT_CYCLES itself; a disabled
    // watchdog (limit 0) still gets a 1-bit counter so the port widths stay legal.
    function automatic int unsigned wdog_width(input int unsigned limit);
        if (limit == 0) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage : bus_arb_pkg
`default_nettype wire

// File: rtl/bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_pick
// Purpose  : Two-way combinational priority pick.
//            A sole requester always wins. When both request, round-robin
//            mode grants the master that did not complete last; fixed mode
//            always grants master 0.
// Ports    : req[1:0]     in   request per master
//            rr_last      in   master that completed the previous transaction
//            grant        out  index of the winning master
//            grant_valid  out  at least one master is requesting
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_pick #(
    parameter bit PRIORITY_RR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant       = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // Conflict: alternate away from the last completer, or M0 wins.
            2'b11:   grant = PRIORITY_RR ? ~rr_last : 1'b0;
            default: grant = 1'b0;
        endcase
    end

endmodule : bus_rr_pick
`default_nettype wire

// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2m
// Purpose  : Shares one memory/peripheral bus between two masters
//            (M0 = CPU data port, M1 = instruction refill / DMA) using the
//            native level-held ren/wen + combinational done protocol.
//            Zero-cycle arbitration in IDLE, ownership lock in BUSY until the
//            slave completes or the owner aborts, and a slave-timeout
//            watchdog that forces completion and records a sticky error.
// Ports    : clk              in   clock, rising edge
//            rst              in   asynchronous reset, active-low
//            mN_addr/wdata    in   master N address / write data (N = 0,1)
//            mN_wmask         in   master N byte write mask
//            mN_wen/ren       in   master N write / read request (level)
//            mN_rdata         out  read data to master N
//            mN_done          out  completion strobe to master N
//            s_addr/wdata     out  slave address / write data
//            s_wmask          out  slave byte write mask
//            s_wen/ren        out  slave write / read request
//            s_rdata          in   slave read data
//            s_done           in   slave completion (combinational-capable)
//            err_timeout      out  sticky watchdog timeout flag
//            err_addr         out  address of the most recent timeout
//            err_clear        in   clears err_timeout
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter bit          PRIORITY_RR    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = BUS_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_wen,
    input  logic        m0_ren,
    output logic [31:0] m0_rdata,
    output logic        m0_done,

    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_wen,
    input  logic        m1_ren,
    output logic [31:0] m1_rdata,
    output logic        m1_done,

    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_wen,
    output logic        s_ren,
    input  logic [31:0] s_rdata,
    input  logic        s_done,

    output logic        err_timeout,
    output logic [31:0] err_addr,
    input  logic        err_clear
);

    localparam int unsigned        WDOG_W     = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
    localparam bit                 WDOG_EN    = (TIMEOUT_CYCLES != 0);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    logic              r_owner;
    logic              r_rr_last;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err_timeout;
    logic [31:0]       r_err_addr;

    // ------------------------------------------------------------------
    // Combinational next-state and selection
    // ------------------------------------------------------------------
    arb_state_t        w_state_nxt;
    logic              w_owner_nxt;
    logic              w_rr_last_nxt;
    logic [WDOG_W-1:0] w_wdog_nxt;
    logic              w_err_nxt;
    logic [31:0]       w_err_addr_nxt;

    bus_req_t          w_mreq [2];
    logic [1:0]        w_req;
    logic              w_grant;
    logic              w_grant_valid;
    logic              w_sel;       // master currently driving the slave
    logic              w_active;    // a live request is being forwarded
    logic              w_timeout;   // forced completion this cycle

    assign w_mreq[0] = '{addr: m0_addr, wdata: m0_wdata, wmask: m0_wmask,
                         wen: m0_wen, ren: m0_ren};
    assign w_mreq[1] = '{addr: m1_addr, wdata: m1_wdata, wmask: m1_wmask,
                         wen: m1_wen, ren: m1_ren};

    // A master requests when either strobe is high; both at once are passed
    // through untouched and the slave decides what that means.
    assign w_req = {m1_ren | m1_wen, m0_ren | m0_wen};

    bus_rr_pick #(
        .PRIORITY_RR (PRIORITY_RR)
    ) u_pick (
        .req         (w_req),
        .rr_last     (r_rr_last),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // ------------------------------------------------------------------
    // Next-state logic and output mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_last_nxt  = r_rr_last;
        w_wdog_nxt     = r_wdog;
        w_err_nxt      = r_err_timeout;
        w_err_addr_nxt = r_err_addr;
        w_sel          = r_owner;
        w_active       = 1'b0;
        w_timeout      = 1'b0;

        s_addr   = '0;
        s_wdata  = '0;
        s_wmask  = '0;
        s_wen    = 1'b0;
        s_ren    = 1'b0;
        m0_done  = 1'b0;
        m1_done  = 1'b0;
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;

        case (r_state)
            ARB_IDLE: begin
                // Winner is forwarded in this same cycle; a slave that
                // completes immediately never takes the FSM out of IDLE.
                w_sel    = w_grant;
                w_active = w_grant_valid;
                if (w_grant_valid) begin
                    if (s_done) begin
                        w_rr_last_nxt = w_grant;
                    end else begin
                        w_owner_nxt = w_grant;
                        w_state_nxt = ARB_BUSY;
                        w_wdog_nxt  = WDOG_W'(1);
                    end
                end
            end
            ARB_BUSY: begin
                // Only the owner is looked at; the other master waits.
                w_sel    = r_owner;
                w_active = w_req[r_owner];
                if (!w_active) begin
                    // Owner aborted: no done, fairness history untouched.
                    w_state_nxt = ARB_IDLE;
                end else if (s_done) begin
                    // Slave completion beats a coincident watchdog expiry.
                    w_rr_last_nxt = r_owner;
                    w_state_nxt   = ARB_IDLE;
                end else if (WDOG_EN && (r_wdog == WDOG_LIMIT)) begin
                    w_timeout      = 1'b1;
                    w_err_addr_nxt = w_mreq[r_owner].addr;
                    w_rr_last_nxt  = r_owner;
                    w_state_nxt    = ARB_IDLE;
                end else if (r_wdog != '1) begin
                    w_wdog_nxt = r_wdog + WDOG_W'(1);
                end
            end
        endcase

        // A timeout in the same cycle as err_clear keeps the flag set.
        if (w_timeout) begin
            w_err_nxt = 1'b1;
        end else if (err_clear) begin
            w_err_nxt = 1'b0;
        end

        // While rst is low the slave and done lines are forced quiet, even
        // though IDLE would otherwise forward a pending request.
        if (rst && w_active) begin
            s_addr  = w_mreq[w_sel].addr;
            s_wdata = w_mreq[w_sel].wdata;
            s_wmask = w_mreq[w_sel].wmask;
            // Forced completion withdraws the request from the stuck slave.
            s_wen   = w_mreq[w_sel].wen & ~w_timeout;
            s_ren   = w_mreq[w_sel].ren & ~w_timeout;
            if (w_sel == MASTER_1) begin
                m1_done = s_done | w_timeout;
                if (w_timeout) begin
                    m1_rdata = ERR_RDATA;
                end
            end else begin
                m0_done = s_done | w_timeout;
                if (w_timeout) begin
                    m0_rdata = ERR_RDATA;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ARB_IDLE;
            r_owner       <= MASTER_0;
            r_rr_last     <= MASTER_1;   // M0 wins the first conflict
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
            r_err_addr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_rr_last     <= w_rr_last_nxt;
            r_wdog        <= w_wdog_nxt;
            r_err_timeout <= w_err_nxt;
            r_err_addr    <= w_err_addr_nxt;
        end
    end

    assign err_timeout = r_err_timeout;
    assign err_addr    = r_err_addr;

endmodule : bus_arbiter_2m
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_2m
// Purpose  : Self-checking bench for bus_arbiter_2m. Two instances share one
//            stimulus stream: A (round-robin, watchdog limit 4) and
//            B (fixed priority, watchdog disabled). A transaction-level model
//            per instance predicts every output each cycle; directed literal
//            checks pin the scenarios of interest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_2m;

    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_wen, m0_ren, m1_wen, m1_ren;
    logic [31:0] s_rdata;
    logic        s_done;
    logic        err_clear;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_err_addr;
    logic        a_m0_done, a_m1_done, a_s_wen, a_s_ren, a_err_timeout;
    logic [3:0]  a_s_wmask;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_err_addr;
    logic        b_m0_done, b_m1_done, b_s_wen, b_s_ren, b_err_timeout;
    logic [3:0]  b_s_wmask;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.PRIORITY_RR(1'b1), .TIMEOUT_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(a_m0_rdata), .m0_done(a_m0_done),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(a_m1_rdata), .m1_done(a_m1_done),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wmask(a_s_wmask),
        .s_wen(a_s_wen), .s_ren(a_s_ren), .s_rdata(s_rdata), .s_done(s_done),
        .err_timeout(a_err_timeout), .err_addr(a_err_addr), .err_clear(err_clear)
    );

    bus_arbiter_2m #(.PRIORITY_RR(1'b0), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(b_m0_rdata), .m0_done(b_m0_done),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(b_m1_rdata), .m1_done(b_m1_done),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wmask(b_s_wmask),
        .s_wen(b_s_wen), .s_ren(b_s_ren), .s_rdata(s_rdata), .s_done(s_done),
        .err_timeout(b_err_timeout), .err_addr(b_err_addr), .err_clear(err_clear)
    );

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    typedef struct {
        int          owner;     // -1 when the bus is free
        int          start;     // cycle number of the grant that went BUSY
        int          last;      // master that completed most recently
        bit          err;
        logic [31:0] err_addr;
    } mdl_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  wmask;
        logic        wen, ren;
        logic [31:0] rdata0, rdata1;
        logic        done0, done1;
        logic        err;
        logic [31:0] err_addr;
    } exp_t;

    mdl_t ma, mb;

    task automatic model_step(input mdl_t m, input bit rr, input int tmo, input int cur,
                              output mdl_t n, output exp_t e);
        bit req [2];
        int w;
        bit tout;
        n = m; w = -1; tout = 1'b0;
        e.addr = '0; e.wdata = '0; e.wmask = '0; e.wen = 1'b0; e.ren = 1'b0;
        e.done0 = 1'b0; e.done1 = 1'b0;
        e.rdata0 = s_rdata; e.rdata1 = s_rdata;
        e.err = m.err; e.err_addr = m.err_addr;
        if (rst !== 1'b1) begin
            n.owner = -1; n.start = 0; n.last = 1; n.err = 1'b0; n.err_addr = '0;
            e.err = 1'b0; e.err_addr = '0;
            return;
        end
        req[0] = m0_ren | m0_wen;
        req[1] = m1_ren | m1_wen;
        if (m.owner < 0) begin
            if (req[0] && req[1]) w = rr ? 1 - m.last : 0;
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
            if (w >= 0) begin
                if (s_done) n.last = w;
                else begin n.owner = w; n.start = cur; end
            end
        end else if (!req[m.owner]) begin
            n.owner = -1;
        end else begin
            w = m.owner;
            if (s_done) begin
                n.last = w; n.owner = -1;
            end else if (tmo != 0 && (cur - m.start) == tmo) begin
                tout = 1'b1;
                n.err = 1'b1;
                n.err_addr = (w == 1) ? m1_addr : m0_addr;
                n.last = w; n.owner = -1;
            end
        end
        if (w >= 0) begin
            e.addr  = (w == 1) ? m1_addr  : m0_addr;
            e.wdata = (w == 1) ? m1_wdata : m0_wdata;
            e.wmask = (w == 1) ? m1_wmask : m0_wmask;
            e.wen   = tout ? 1'b0 : ((w == 1) ? m1_wen : m0_wen);
            e.ren   = tout ? 1'b0 : ((w == 1) ? m1_ren : m0_ren);
            if (w == 1) begin
                e.done1 = s_done | tout;
                if (tout) e.rdata1 = ERR_WORD;
            end else begin
                e.done0 = s_done | tout;
                if (tout) e.rdata0 = ERR_WORD;
            end
        end
        if (!tout && err_clear) n.err = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_set(input string tag, input exp_t e,
                             input logic [31:0] saddr, input logic [31:0] swdata,
                             input logic [3:0] swmask, input logic swen, input logic sren,
                             input logic [31:0] r0, input logic [31:0] r1,
                             input logic d0, input logic d1,
                             input logic et, input logic [31:0] ea);
        chk({tag, ".s_addr"},   saddr,  e.addr);
        chk({tag, ".s_wdata"},  swdata, e.wdata);
        chk({tag, ".s_wmask"},  {28'h0, swmask}, {28'h0, e.wmask});
        chk({tag, ".s_wen"},    {31'h0, swen}, {31'h0, e.wen});
        chk({tag, ".s_ren"},    {31'h0, sren}, {31'h0, e.ren});
        chk({tag, ".m0_rdata"}, r0, e.rdata0);
        chk({tag, ".m1_rdata"}, r1, e.rdata1);
        chk({tag, ".m0_done"},  {31'h0, d0}, {31'h0, e.done0});
        chk({tag, ".m1_done"},  {31'h0, d1}, {31'h0, e.done1});
        chk({tag, ".err_timeout"}, {31'h0, et}, {31'h0, e.err});
        chk({tag, ".err_addr"}, ea, e.err_addr);
    endtask

    // One compare per cycle, away from the active edge.
    always @(negedge clk) begin
        mdl_t na, nb;
        exp_t ea, eb;
        model_step(ma, 1'b1, 4, cyc, na, ea);
        model_step(mb, 1'b0, 0, cyc, nb, eb);
        check_set("A", ea, a_s_addr, a_s_wdata, a_s_wmask, a_s_wen, a_s_ren,
                  a_m0_rdata, a_m1_rdata, a_m0_done, a_m1_done, a_err_timeout, a_err_addr);
        check_set("B", eb, b_s_addr, b_s_wdata, b_s_wmask, b_s_wen, b_s_ren,
                  b_m0_rdata, b_m1_rdata, b_m0_done, b_m1_done, b_err_timeout, b_err_addr);
        ma = na;
        mb = nb;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        m0_ren = 1'b0; m0_wen = 1'b0; m1_ren = 1'b0; m1_wen = 1'b0;
        s_done = 1'b0; err_clear = 1'b0;
    endtask

    task automatic do_reset();
        tick(); drop_all(); rst = 1'b0;
        tick(); rst = 1'b1;
    endtask

    int cnt_a0, cnt_a1, cnt_b0, cnt_b1;

    initial begin
        ma = '{owner: -1, start: 0, last: 1, err: 1'b0, err_addr: '0};
        mb = '{owner: -1, start: 0, last: 1, err: 1'b0, err_addr: '0};
        rst = 1'b0;
        m0_addr = 32'h0; m0_wdata = 32'h0; m0_wmask = 4'h0;
        m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        s_rdata = 32'h0;
        drop_all();
        // Reset holds the slave side quiet even with a request pending.
        m0_ren = 1'b1; m0_addr = 32'h40; s_done = 1'b1;
        #2;
        chk("rst_s_ren", {31'h0, a_s_ren}, 32'h0);
        chk("rst_m0_done", {31'h0, a_m0_done}, 32'h0);
        chk("rst_err", {31'h0, a_err_timeout}, 32'h0);
        chk("rst_err_addr", a_err_addr, 32'h0);
        tick();
        tick(); drop_all(); rst = 1'b1;

        // 1: single-cycle read by M0.
        tick(); m0_addr = 32'h100; m0_ren = 1'b1; s_done = 1'b1; s_rdata = 32'h1234;
        #1;
        chk("t1_m0_done", {31'h0, a_m0_done}, 32'h1);
        chk("t1_m0_rdata", a_m0_rdata, 32'h1234);
        chk("t1_s_addr", a_s_addr, 32'h100);
        tick(); drop_all();

        // 2: round-robin conflict, 3-cycle slave.
        do_reset();
        tick(); m0_addr = 32'hA0; m0_ren = 1'b1; m1_addr = 32'hB0; m1_ren = 1'b1; s_rdata = 32'h11;
        #1; chk("t2_first_m0", a_s_addr, 32'hA0);
        tick(); #1; chk("t2_lock", a_s_addr, 32'hA0);
        tick(); s_done = 1'b1;
        #1; chk("t2_m0_done", {31'h0, a_m0_done}, 32'h1);
        chk("t2_m1_wait", {31'h0, a_m1_done}, 32'h0);
        tick(); s_done = 1'b0; m0_addr = 32'hA4;
        #1; chk("t2_then_m1", a_s_addr, 32'hB0);
        tick();
        tick(); s_done = 1'b1;
        #1; chk("t2_m1_done", {31'h0, a_m1_done}, 32'h1);
        tick(); s_done = 1'b0; m1_ren = 1'b0;
        #1; chk("t2_m0_again", a_s_addr, 32'hA4);
        tick();
        tick(); s_done = 1'b1;
        #1; chk("t2_m0_done2", {31'h0, a_m0_done}, 32'h1);
        tick(); drop_all();
        tick();

        // 3: continuous conflict with a 1-cycle slave.
        cnt_a0 = 0; cnt_a1 = 0; cnt_b0 = 0; cnt_b1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            m0_ren = 1'b1; m0_addr = 32'h1000 + i; m1_ren = 1'b1; m1_addr = 32'h2000 + i;
            s_done = 1'b1; s_rdata = 32'h500 + i;
            #1;
            cnt_a0 += int'(a_m0_done); cnt_a1 += int'(a_m1_done);
            cnt_b0 += int'(b_m0_done); cnt_b1 += int'(b_m1_done);
        end
        chk("t3_fixed_m0_count", cnt_b0, 8);
        chk("t3_fixed_m1_count", cnt_b1, 0);
        chk("t3_rr_m0_count", cnt_a0, 4);
        chk("t3_rr_m1_count", cnt_a1, 4);
        tick(); drop_all();

        // 4: M1 write owns the bus while M0 waits.
        tick(); m1_addr = 32'h2000; m1_wdata = 32'hCAFE0000; m1_wmask = 4'hC; m1_wen = 1'b1;
        #1; chk("t4_s_wen", {31'h0, a_s_wen}, 32'h1);
        tick(); m0_addr = 32'h300; m0_ren = 1'b1;
        #1; chk("t4_hold_addr", a_s_addr, 32'h2000);
        chk("t4_no_ren", {31'h0, a_s_ren}, 32'h0);
        tick(); #1; chk("t4_hold_addr2", a_s_addr, 32'h2000);
        tick(); s_done = 1'b1;
        #1; chk("t4_m1_done", {31'h0, a_m1_done}, 32'h1);
        chk("t4_m0_not_done", {31'h0, a_m0_done}, 32'h0);
        tick(); s_done = 1'b0; m1_wen = 1'b0;
        #1; chk("t4_m0_granted", a_s_addr, 32'h300);
        chk("t4_m0_ren", {31'h0, a_s_ren}, 32'h1);
        tick(); s_done = 1'b1;
        tick(); drop_all();

        // 5: watchdog timeout on a dead slave, then err_clear.
        tick(); m0_addr = 32'hBEEF0; m0_ren = 1'b1; s_rdata = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            tick(); #1; chk("t5_no_early_done", {31'h0, a_m0_done}, 32'h0);
        end
        tick(); #1;
        chk("t5_forced_done", {31'h0, a_m0_done}, 32'h1);
        chk("t5_err_rdata", a_m0_rdata, 32'hDEADBEEF);
        chk("t5_s_ren_drop", {31'h0, a_s_ren}, 32'h0);
        tick(); m0_ren = 1'b0;
        #1; chk("t5_err_flag", {31'h0, a_err_timeout}, 32'h1);
        chk("t5_err_addr", a_err_addr, 32'hBEEF0);
        tick(); err_clear = 1'b1;
        tick(); err_clear = 1'b0;
        #1; chk("t5_err_cleared", {31'h0, a_err_timeout}, 32'h0);
        chk("t5_err_addr_kept", a_err_addr, 32'hBEEF0);
        // Timeout coinciding with err_clear keeps the flag.
        tick(); m1_addr = 32'h7770; m1_ren = 1'b1; err_clear = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick(); m1_ren = 1'b0; err_clear = 1'b0;
        #1; chk("t5_timeout_beats_clear", {31'h0, a_err_timeout}, 32'h1);
        chk("t5_err_addr2", a_err_addr, 32'h7770);
        tick(); err_clear = 1'b1;
        tick(); err_clear = 1'b0;
        // Slave completes in the very cycle the watchdog would fire.
        tick(); m0_addr = 32'h440; m0_ren = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tick(); s_done = 1'b1; s_rdata = 32'h99;
        #1; chk("t5_late_done", {31'h0, a_m0_done}, 32'h1);
        chk("t5_late_rdata", a_m0_rdata, 32'h99);
        tick(); drop_all();
        #1; chk("t5_no_error", {31'h0, a_err_timeout}, 32'h0);

        // 6a: reset while BUSY.
        tick(); m0_addr = 32'h500; m0_ren = 1'b1;
        tick(); #1; rst = 1'b0; s_done = 1'b1;
        #1; chk("t6_rst_s_ren", {31'h0, a_s_ren}, 32'h0);
        chk("t6_rst_no_done", {31'h0, a_m0_done}, 32'h0);
        tick(); drop_all();
        tick(); rst = 1'b1;
        #1; chk("t6_rst_err_addr", a_err_addr, 32'h0);
        // 6b: owner aborts mid-BUSY.
        tick(); m0_addr = 32'h600; m0_ren = 1'b1;
        tick();
        tick(); m0_ren = 1'b0;
        #1; chk("t6_abort_s_ren", {31'h0, a_s_ren}, 32'h0);
        chk("t6_abort_no_done", {31'h0, a_m0_done}, 32'h0);
        tick(); m1_addr = 32'h700; m1_ren = 1'b1;
        #1; chk("t6_idle_grant", a_s_addr, 32'h700);
        chk("t6_idle_ren", {31'h0, a_s_ren}, 32'h1);
        tick(); s_done = 1'b1;
        tick(); drop_all();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bus_arbiter_2m
`default_nettype wire
